// File: rtl/ahb_lite_cmd_master_if.sv
// Bundle of the command/response stream and the AHB-Lite manager-side bus
// signals of ahb_lite_cmd_master. The master modport is the initiator's view
// and the slave modport is the view of whoever feeds commands and plays the
// subordinate.
`timescale 1ns/1ps
interface ahb_lite_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response stream
    logic              rsp_valid;
    logic              rsp_write;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;

    // AHB-Lite manager signals
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_addr, rsp_rdata,
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_addr, rsp_rdata,
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRDATA
    );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into single-word
// NONSEQ transfers. Commands sit in a small FIFO whose head drives the address
// phase directly, so the address phase of one transfer overlaps the data phase
// of the previous one. Every completed transfer yields a one-cycle response.
`timescale 1ns/1ps
module ahb_lite_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_cmd_master_if.master bus,
    output logic                 err_timeout,
    output logic [15:0]          txn_count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    // One spare count above TIMEOUT so the saturating counter never wraps
    // back through the limit value.
    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    localparam logic [CNT_W-1:0]  FULL_CNT      = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT    = WAIT_W'(TIMEOUT);
    localparam bit                TIMEOUT_EN    = (TIMEOUT != 0);
    localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]        HSIZE_WORD    = 3'b010;

    // Command FIFO storage (no reset needed: only pointers/count define validity)
    logic              fifo_write_reg [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_reg  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata_reg [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg,  count_next;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  entry_we;

    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    // Data-phase register
    logic              dp_valid_reg, dp_valid_next;
    logic              dp_write_reg, dp_write_next;
    logic [ADDR_W-1:0] dp_addr_reg,  dp_addr_next;
    logic [DATA_W-1:0] dp_wdata_reg, dp_wdata_next;

    // Response register
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_write_reg, rsp_write_next;
    logic [ADDR_W-1:0] rsp_addr_reg,  rsp_addr_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

    // Status
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;
    logic [15:0]       txn_cnt_reg, txn_cnt_next;

    logic              completion;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    // cmd_ready comes from registered occupancy only, so nothing on cmd_*
    // reaches it combinationally; a full FIFO never pushes, even on a pop.
    assign push       = bus.cmd_valid && !fifo_full;
    // The head is consumed whenever the bus accepts an address phase.
    assign pop        = bus.HREADY && !fifo_empty;

    assign bus.cmd_ready = !fifo_full;

    // One write enable per storage entry, selected by the tail pointer
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
        assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end

    // Tail write into FIFO storage
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                fifo_write_reg[i] <= bus.cmd_write;
                fifo_addr_reg[i]  <= bus.cmd_addr;
                fifo_wdata_reg[i] <= bus.cmd_wdata;
            end
        end
    end

    assign head_write = fifo_write_reg[rd_ptr_reg];
    assign head_addr  = fifo_addr_reg[rd_ptr_reg];
    assign head_wdata = fifo_wdata_reg[rd_ptr_reg];

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n)
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointer/occupancy registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Address phase: driven straight from the FIFO head, so it holds
    // stable through wait states because the head only moves on a pop.
    // ------------------------------------------------------------------
    always_comb begin
        bus.HTRANS = HTRANS_IDLE;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        if (!fifo_empty) begin
            bus.HTRANS = HTRANS_NONSEQ;
            bus.HADDR  = {head_addr[ADDR_W-1:2], 2'b00};
            bus.HWRITE = head_write;
        end
    end

    assign bus.HSEL  = bus.HTRANS[1];
    assign bus.HSIZE = HSIZE_WORD;

    // ------------------------------------------------------------------
    // Data phase
    // ------------------------------------------------------------------
    // Advance the data phase only when the bus is ready; hold otherwise
    always_comb begin
        dp_valid_next = dp_valid_reg;
        dp_write_next = dp_write_reg;
        dp_addr_next  = dp_addr_reg;
        dp_wdata_next = dp_wdata_reg;
        if (bus.HREADY) begin
            dp_valid_next = pop;
            if (pop) begin
                dp_write_next = head_write;
                dp_addr_next  = head_addr;
                dp_wdata_next = head_wdata;
            end
        end
    end

    // Data-phase registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_addr_reg  <= '0;
            dp_wdata_reg <= '0;
        end else begin
            dp_valid_reg <= dp_valid_next;
            dp_write_reg <= dp_write_next;
            dp_addr_reg  <= dp_addr_next;
            dp_wdata_reg <= dp_wdata_next;
        end
    end

    assign bus.HWDATA = (dp_valid_reg && dp_write_reg) ? dp_wdata_reg : '0;

    // ------------------------------------------------------------------
    // Completion, response and counters
    // ------------------------------------------------------------------
    assign completion = dp_valid_reg && bus.HREADY;

    // Response fields load on completion; they keep their last value otherwise
    always_comb begin
        rsp_valid_next = completion;
        rsp_write_next = rsp_write_reg;
        rsp_addr_next  = rsp_addr_reg;
        rsp_rdata_next = rsp_rdata_reg;
        txn_cnt_next   = txn_cnt_reg;
        if (completion) begin
            rsp_write_next = dp_write_reg;
            rsp_addr_next  = dp_addr_reg;
            rsp_rdata_next = dp_write_reg ? '0 : bus.HRDATA;
            txn_cnt_next   = txn_cnt_reg + 16'd1;
        end
    end

    // Response and transfer-count registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_addr_reg  <= '0;
            rsp_rdata_reg <= '0;
            txn_cnt_reg   <= '0;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            rsp_write_reg <= rsp_write_next;
            rsp_addr_reg  <= rsp_addr_next;
            rsp_rdata_reg <= rsp_rdata_next;
            txn_cnt_reg   <= txn_cnt_next;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_write = rsp_write_reg;
    assign bus.rsp_addr  = rsp_addr_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign txn_count     = txn_cnt_reg;

    // Count consecutive wait states of a pending data phase; the flag is
    // raised on the very edge the count reaches the limit and then sticks.
    always_comb begin
        wait_cnt_next = '0;
        if (dp_valid_reg && !bus.HREADY) begin
            wait_cnt_next = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
        end
        err_next = err_reg || (TIMEOUT_EN && (wait_cnt_next == WAIT_LIMIT));
    end

    // Wait counter and sticky timeout flag
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end

    assign err_timeout = err_reg;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed command sequences, a queue-based
// transaction model compared against the DUT on every falling edge, and
// literal expectations taken from hand-worked timelines.
`timescale 1ns/1ps
`define CHK(nm, act, exp) check(nm, 64'(act), 64'(exp))
module tb_ahb_lite_cmd_master;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        hclk   = 1'b0;
    logic        hreset = 1'b1;
    logic        err_timeout;
    logic [15:0] txn_count;

    ahb_lite_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    ahb_lite_cmd_master #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK       (hclk),
        .HRESET     (hreset),
        .bus        (bus_if),
        .err_timeout(err_timeout),
        .txn_count  (txn_count)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        int            cyc;
    } rsp_t;

    // Transaction model state
    cmd_t          mq[$];
    bit            m_dp_v   = 1'b0;
    cmd_t          m_dp;
    bit            m_rsp_v  = 1'b0;
    logic          m_rsp_w  = 1'b0;
    logic [AW-1:0] m_rsp_a  = '0;
    logic [DW-1:0] m_rsp_d  = '0;
    logic [15:0]   m_cnt    = '0;
    bit            m_err    = 1'b0;
    int            m_wait   = 0;
    bit            m_full;
    int            m_n;

    rsp_t rsp_log[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    task automatic bound_expired(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", nm, cycle);
    endtask

    // Model: advance one bus cycle using the inputs present at the edge
    initial forever begin
        @(posedge hclk);
        cycle++;
        if (hreset) begin
            mq.delete();
            m_dp_v  = 1'b0;
            m_rsp_v = 1'b0;
            m_cnt   = '0;
            m_err   = 1'b0;
            m_wait  = 0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_rsp_v = 1'b0;
            if (m_dp_v && bus_if.HREADY) begin
                m_rsp_v = 1'b1;
                m_rsp_w = m_dp.write;
                m_rsp_a = m_dp.addr;
                m_rsp_d = m_dp.write ? '0 : bus_if.HRDATA;
                m_cnt   = m_cnt + 16'd1;
            end
            if (m_dp_v && !bus_if.HREADY) begin
                m_wait++;
                if (m_wait >= TIMEOUT) m_err = 1'b1;
            end else begin
                m_wait = 0;
            end
            if (bus_if.HREADY) begin
                if (mq.size() > 0) begin
                    m_dp   = mq.pop_front();
                    m_dp_v = 1'b1;
                end else begin
                    m_dp_v = 1'b0;
                end
            end
            if (bus_if.cmd_valid && !m_full)
                mq.push_back(cmd_t'{bus_if.cmd_write, bus_if.cmd_addr, bus_if.cmd_wdata});
        end
    end

    // Compare DUT against the model mid-cycle and log responses
    initial forever begin
        @(negedge hclk);
        if (chk_en) begin
            m_n = mq.size();
            `CHK("cmd_ready", bus_if.cmd_ready, m_n < DEPTH);
            `CHK("htrans", bus_if.HTRANS, (m_n > 0) ? 2'b10 : 2'b00);
            `CHK("hsel", bus_if.HSEL, m_n > 0);
            `CHK("haddr", bus_if.HADDR, (m_n > 0) ? (mq[0].addr & ~32'h3) : 32'h0);
            `CHK("hwrite", bus_if.HWRITE, (m_n > 0) ? mq[0].write : 1'b0);
            `CHK("hsize", bus_if.HSIZE, 3'b010);
            `CHK("hwdata", bus_if.HWDATA, (m_dp_v && m_dp.write) ? m_dp.wdata : 32'h0);
            `CHK("rsp_valid", bus_if.rsp_valid, m_rsp_v);
            if (m_rsp_v) begin
                `CHK("rsp_write", bus_if.rsp_write, m_rsp_w);
                `CHK("rsp_addr", bus_if.rsp_addr, m_rsp_a);
                `CHK("rsp_rdata", bus_if.rsp_rdata, m_rsp_d);
            end
            `CHK("txn_count", txn_count, m_cnt);
            `CHK("err_timeout", err_timeout, m_err);
            if (bus_if.rsp_valid === 1'b1) begin
                rsp_log.push_back('{bus_if.rsp_write, bus_if.rsp_addr, bus_if.rsp_rdata, cycle});
                $display("rsp cycle %0d: %s addr=%h rdata=%h txn_count=%0d", cycle,
                         bus_if.rsp_write ? "WR" : "RD", bus_if.rsp_addr, bus_if.rsp_rdata, txn_count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_if.cmd_valid = v;
        bus_if.cmd_write = w;
        bus_if.cmd_addr  = a;
        bus_if.cmd_wdata = d;
    endtask

    // Present one command and return just after the edge that accepted it
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        drive(1'b1, w, a, d);
        while (bus_if.cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) bound_expired("send_ready");
        tick();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_log.size() < n && k < 100) begin
            tick();
            k++;
        end
        if (rsp_log.size() < n) bound_expired("wait_rsp");
    endtask

    logic [AW-1:0] t3_addr [4];
    logic          t3_wr   [4];
    logic [DW-1:0] t3_rd   [4];
    logic [AW-1:0] t4_addr [5];
    logic [DW-1:0] t4_rd   [5];

    initial begin
        t3_addr = '{32'h4, 32'h0, 32'h4, 32'h0};
        t3_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
        t3_rd   = '{32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678};
        t4_addr = '{32'h8, 32'h10, 32'h14, 32'h1B, 32'h1C};
        t4_rd   = '{32'h0, 32'hC3, 32'h0, 32'hC3, 32'h0};

        drive(1'b0, 1'b0, '0, '0);
        bus_if.HREADY = 1'b1;
        bus_if.HRDATA = '0;
        hreset = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge hclk);
        `CHK("rst_htrans", bus_if.HTRANS, 2'b00);
        `CHK("rst_hsel", bus_if.HSEL, 1'b0);
        `CHK("rst_haddr", bus_if.HADDR, 32'h0);
        `CHK("rst_hwdata", bus_if.HWDATA, 32'h0);
        `CHK("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        `CHK("rst_cmd_ready", bus_if.cmd_ready, 1'b1);
        `CHK("rst_txn_count", txn_count, 16'h0);
        `CHK("rst_err", err_timeout, 1'b0);
        chk_en = 1'b1;
        tick();
        hreset = 1'b0;
        tick();

        // Single write 0x4 <- 0xA5
        rsp_log.delete();
        send(1'b1, 32'h4, 32'hA5);
        @(negedge hclk);
        `CHK("t1_htrans", bus_if.HTRANS, 2'b10);
        `CHK("t1_hwrite", bus_if.HWRITE, 1'b1);
        `CHK("t1_haddr", bus_if.HADDR, 32'h4);
        @(negedge hclk);
        `CHK("t1_hwdata", bus_if.HWDATA, 32'hA5);
        tick();
        wait_rsp(1);
        if (rsp_log.size() >= 1) begin
            `CHK("t1_rsp_write", rsp_log[0].write, 1'b1);
            `CHK("t1_rsp_addr", rsp_log[0].addr, 32'h4);
            `CHK("t1_rsp_rdata", rsp_log[0].rdata, 32'h0);
        end
        `CHK("t1_txn_count", txn_count, 16'd1);

        // Single read 0x0 returning 0x5A, response two cycles after address phase
        bus_if.HRDATA = 32'h0000_005A;
        send(1'b0, 32'h0, 32'h0);
        @(negedge hclk);
        `CHK("t2_htrans", bus_if.HTRANS, 2'b10);
        `CHK("t2_hwrite", bus_if.HWRITE, 1'b0);
        @(negedge hclk);
        @(negedge hclk);
        `CHK("t2_rsp_valid", bus_if.rsp_valid, 1'b1);
        `CHK("t2_rsp_write", bus_if.rsp_write, 1'b0);
        `CHK("t2_rsp_addr", bus_if.rsp_addr, 32'h0);
        `CHK("t2_rsp_rdata", bus_if.rsp_rdata, 32'h5A);
        `CHK("t2_txn_count", txn_count, 16'd2);
        tick();
        repeat (2) tick();

        // Four back-to-back commands, zero wait states
        rsp_log.delete();
        bus_if.HRDATA = 32'h1234_5678;
        send(1'b1, 32'h4, 32'h1);
        send(1'b0, 32'h0, 32'h0);
        send(1'b1, 32'h4, 32'h2);
        send(1'b0, 32'h0, 32'h0);
        wait_rsp(4);
        if (rsp_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                `CHK($sformatf("t3_addr%0d", i), rsp_log[i].addr, t3_addr[i]);
                `CHK($sformatf("t3_write%0d", i), rsp_log[i].write, t3_wr[i]);
                `CHK($sformatf("t3_rdata%0d", i), rsp_log[i].rdata, t3_rd[i]);
                `CHK($sformatf("t3_consec%0d", i), rsp_log[i].cyc - rsp_log[0].cyc, i);
            end
        end
        `CHK("t3_txn_count", txn_count, 16'd6);
        repeat (2) tick();

        // Three wait states in a write data phase while filling the FIFO
        rsp_log.delete();
        bus_if.HRDATA = 32'h0000_00C3;
        drive(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        bus_if.HREADY = 1'b0;
        drive(1'b1, 1'b1, 32'h14, 32'h33);
        @(negedge hclk);
        `CHK("t4_hwdata_w1", bus_if.HWDATA, 32'hDEAD_BEEF);
        `CHK("t4_haddr_w1", bus_if.HADDR, 32'h10);
        `CHK("t4_hwrite_w1", bus_if.HWRITE, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h1B, 32'h0);
        @(negedge hclk);
        `CHK("t4_hwdata_w2", bus_if.HWDATA, 32'hDEAD_BEEF);
        `CHK("t4_haddr_w2", bus_if.HADDR, 32'h10);
        tick();
        drive(1'b1, 1'b1, 32'h1C, 32'h44);
        @(negedge hclk);
        `CHK("t4_haddr_w3", bus_if.HADDR, 32'h10);
        `CHK("t4_ready_w3", bus_if.cmd_ready, 1'b1);
        tick();
        bus_if.HREADY = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        @(negedge hclk);
        `CHK("t4_ready_full", bus_if.cmd_ready, 1'b0);
        tick();
        wait_rsp(5);
        if (rsp_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                `CHK($sformatf("t4_addr%0d", i), rsp_log[i].addr, t4_addr[i]);
                `CHK($sformatf("t4_rdata%0d", i), rsp_log[i].rdata, t4_rd[i]);
            end
        end
        repeat (2) tick();

        // Timeout after eight consecutive wait cycles, flag sticks afterwards
        rsp_log.delete();
        `CHK("t5_err_before", err_timeout, 1'b0);
        send(1'b1, 32'h20, 32'h55);
        tick();
        bus_if.HREADY = 1'b0;
        repeat (7) tick();
        @(negedge hclk);
        `CHK("t5_err_after7", err_timeout, 1'b0);
        tick();
        @(negedge hclk);
        `CHK("t5_err_after8", err_timeout, 1'b1);
        `CHK("t5_hwdata_hold", bus_if.HWDATA, 32'h55);
        tick();
        bus_if.HREADY = 1'b1;
        wait_rsp(1);
        send(1'b0, 32'h24, 32'h0);
        wait_rsp(2);
        `CHK("t5_err_sticky", err_timeout, 1'b1);
        repeat (2) tick();

        // Reset during a read data phase with two commands queued
        rsp_log.delete();
        bus_if.HRDATA = 32'h77;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h4, 32'h11);
        tick();
        bus_if.HREADY = 1'b0;
        drive(1'b1, 1'b1, 32'h8, 32'h22);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        bus_if.HREADY = 1'b1;
        @(negedge hclk);
        `CHK("t6_htrans", bus_if.HTRANS, 2'b00);
        `CHK("t6_cmd_ready", bus_if.cmd_ready, 1'b1);
        `CHK("t6_rsp_valid", bus_if.rsp_valid, 1'b0);
        `CHK("t6_txn_count", txn_count, 16'h0);
        `CHK("t6_err", err_timeout, 1'b0);
        repeat (3) tick();
        `CHK("t6_no_rsp", rsp_log.size(), 0);
        send(1'b1, 32'h4, 32'h99);
        wait_rsp(1);
        `CHK("t6_txn_after", txn_count, 16'd1);
        if (rsp_log.size() >= 1) `CHK("t6_rsp_addr", rsp_log[0].addr, 32'h4);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
